// File: rtl/i2c_bus_bridge.sv
// Processor-bus slave that turns single-cycle register accesses into the
// level-held four-phase command handshake of the I2C master PHY.
module i2c_bus_bridge #(
    parameter int   BUS_W      = 32,
    parameter logic IRQ_EN_RST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       bus_addr,
    input  logic [BUS_W-1:0] bus_wdata,
    input  logic             bus_we,
    input  logic             bus_re,
    output logic [BUS_W-1:0] bus_rdata,
    output logic             bus_ack,
    output logic             irq,
    output logic             phy_read,
    output logic             phy_write,
    output logic             phy_rcount_set,
    output logic             phy_enq,
    output logic             phy_deq,
    output logic             phy_clear,
    output logic [7:0]       phy_din,
    input  logic [7:0]       phy_dout,
    input  logic             phy_ack,
    input  logic             phy_nack,
    input  logic             phy_empty,
    input  logic             phy_full
);

    typedef enum logic [2:0] {IDLE, S_REQ, S_REL, B_ACK, B_WAIT, T_REQ, T_REL} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_RCNT, OP_CLR, OP_RD, OP_WR} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       count_q, count_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             irqEn_q, irqEn_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tAck_q, tAck_d;
    logic             tWait_q, tWait_d;

    logic             req;
    logic             accept;
    logic [BUS_W-1:0] statusWord;
    logic             unusedWdata;

    assign req         = bus_we | bus_re;
    assign unusedWdata = ^bus_wdata[BUS_W-1:8];

    always_comb begin
        statusWord      = '0;
        statusWord[5:0] = {done_q, irqEn_q, busy_q, phy_nack, phy_full, phy_empty};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            din_q   <= '0;
            count_q <= '0;
            rdata_q <= '0;
            irqEn_q <= IRQ_EN_RST;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            tAck_q  <= 1'b0;
            tWait_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            din_q   <= din_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            irqEn_q <= irqEn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tAck_q  <= tAck_d;
            tWait_q <= tWait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        din_d   = din_q;
        count_d = count_q;
        rdata_d = rdata_q;
        irqEn_d = irqEn_q;
        done_d  = done_q;
        busy_d  = busy_q;
        tAck_d  = 1'b0;
        tWait_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = B_ACK;
                    case (bus_addr)
                        2'd0: begin
                            if (bus_we) begin
                                if (!phy_full) begin
                                    din_d   = bus_wdata[7:0];
                                    op_d    = OP_ENQ;
                                    state_d = S_REQ;
                                end
                            end else if (phy_empty) begin
                                rdata_d = '0;
                            end else begin
                                op_d    = OP_DEQ;
                                state_d = S_REQ;
                            end
                        end
                        2'd1: begin
                            if (bus_we) begin
                                din_d   = bus_wdata[7:0];
                                count_d = bus_wdata[7:0];
                                op_d    = OP_RCNT;
                                state_d = S_REQ;
                            end else begin
                                rdata_d      = '0;
                                rdata_d[7:0] = count_q;
                            end
                        end
                        2'd2: begin
                            if (!bus_we) begin
                                rdata_d = '0;
                            end else if (bus_wdata[2]) begin
                                op_d    = OP_CLR;
                                state_d = S_REQ;
                            end else if (bus_wdata[1] || bus_wdata[0]) begin
                                // Transfers run in the background; the bus is released next cycle.
                                op_d    = bus_wdata[1] ? OP_RD : OP_WR;
                                busy_d  = 1'b1;
                                done_d  = 1'b0;
                                tAck_d  = 1'b1;
                                state_d = T_REQ;
                            end
                        end
                        default: begin
                            if (bus_we) begin
                                irqEn_d = bus_wdata[4];
                                if (bus_wdata[5]) done_d = 1'b0;
                            end else begin
                                rdata_d = statusWord;
                            end
                        end
                    endcase
                end
            end
            S_REQ: begin
                if (phy_ack) begin
                    state_d = S_REL;
                    if (op_q == OP_DEQ) begin
                        rdata_d      = '0;
                        rdata_d[7:0] = phy_dout;
                    end
                end
            end
            S_REL:  if (!phy_ack) state_d = B_ACK;
            B_ACK:  state_d = B_WAIT;
            B_WAIT: if (!req) state_d = IDLE;
            T_REQ, T_REL: begin
                // Side channel serving bus accesses while a transfer is in flight.
                if (tAck_q) begin
                    tWait_d = 1'b1;
                end else if (tWait_q) begin
                    tWait_d = req;
                end else if (req) begin
                    accept = 1'b1;
                    if (bus_addr == 2'd3) begin
                        if (bus_we) begin
                            irqEn_d = bus_wdata[4];
                            if (bus_wdata[5]) done_d = 1'b0;
                        end else begin
                            rdata_d = statusWord;
                        end
                    end else if (!bus_we) begin
                        rdata_d = '0;
                    end
                end
                if (state_q == T_REQ && phy_ack) state_d = T_REL;
                if (state_q == T_REL && !phy_ack) begin
                    // Completion overrides a done-clear arriving in the same cycle.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tWait_d = 1'b0;
                    if (accept)                state_d = B_ACK;
                    else if (tAck_q || tWait_q) state_d = B_WAIT;
                    else                       state_d = IDLE;
                end else begin
                    tAck_d = accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_rdata      = rdata_q;
    assign bus_ack        = (state_q == B_ACK) | tAck_q;
    assign irq            = done_q & irqEn_q;
    assign phy_din        = din_q;
    assign phy_enq        = (state_q == S_REQ) && (op_q == OP_ENQ);
    assign phy_deq        = (state_q == S_REQ) && (op_q == OP_DEQ);
    assign phy_rcount_set = (state_q == S_REQ) && (op_q == OP_RCNT);
    assign phy_clear      = (state_q == S_REQ) && (op_q == OP_CLR);
    assign phy_read       = (state_q == T_REQ) && (op_q == OP_RD);
    assign phy_write      = (state_q == T_REQ) && (op_q == OP_WR);

endmodule

// File: tb/tb_i2c_bus_bridge.sv
// Directed bench for i2c_bus_bridge: a reactive PHY handshake model, a vector
// table of single register accesses and hand sequences for transfer corner cases.
module tb_i2c_bus_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        irq;
    logic        phy_read, phy_write, phy_rcount_set, phy_enq, phy_deq, phy_clear;
    logic [7:0]  phy_din;
    logic [7:0]  phy_dout;
    logic        phy_ack = 1'b0;
    logic        phy_nack;
    logic        phy_empty;
    logic        phy_full;

    int checks = 0;
    int fails  = 0;

    int phyDelay = 2;
    int phyCnt   = 0;
    int enqCnt = 0, deqCnt = 0, rcntCnt = 0, clrCnt = 0, rdCnt = 0, wrCnt = 0;
    int oneHotErr = 0, dinErr = 0;
    logic [7:0] lastDin = 8'h00;
    logic [7:0] prevDin = 8'h00;
    logic       prevCmd = 1'b0;
    logic       anyCmd;

    i2c_bus_bridge #(.BUS_W(32), .IRQ_EN_RST(1'b0)) dut (
        .clock(clock), .reset(reset),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .irq(irq),
        .phy_read(phy_read), .phy_write(phy_write), .phy_rcount_set(phy_rcount_set),
        .phy_enq(phy_enq), .phy_deq(phy_deq), .phy_clear(phy_clear),
        .phy_din(phy_din), .phy_dout(phy_dout), .phy_ack(phy_ack), .phy_nack(phy_nack),
        .phy_empty(phy_empty), .phy_full(phy_full)
    );

    always #5 clock = ~clock;

    // PHY model: raise ack phyDelay cycles after a command, drop it phyDelay cycles after release.
    always @(negedge clock) begin
        anyCmd = phy_read | phy_write | phy_rcount_set | phy_enq | phy_deq | phy_clear;
        if (reset) begin
            phy_ack = 1'b0;
            phyCnt  = 0;
        end else begin
            if ($countones({phy_read, phy_write, phy_rcount_set, phy_enq, phy_deq, phy_clear}) > 1)
                oneHotErr++;
            if (anyCmd && prevCmd && (phy_din != prevDin)) dinErr++;
            if (anyCmd && !phy_ack) begin
                phyCnt++;
                if (phyCnt >= phyDelay) begin
                    phy_ack = 1'b1;
                    phyCnt  = 0;
                    lastDin = phy_din;
                    if (phy_enq)        enqCnt++;
                    if (phy_deq)        deqCnt++;
                    if (phy_rcount_set) rcntCnt++;
                    if (phy_clear)      clrCnt++;
                    if (phy_read)       rdCnt++;
                    if (phy_write)      wrCnt++;
                end
            end else if (!anyCmd && phy_ack) begin
                phyCnt++;
                if (phyCnt >= phyDelay) begin
                    phy_ack = 1'b0;
                    phyCnt  = 0;
                end
            end else begin
                phyCnt = 0;
            end
        end
        prevCmd = anyCmd;
        prevDin = phy_din;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one access, hold it until bus_ack (plus holdExtra cycles), then idle two cycles.
    task automatic applyStimulus(input logic [1:0] addr, input logic we, input logic [31:0] wdata,
                                 input int holdExtra, output logic [31:0] rdata, output int cycles);
        bit gotAck = 0;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_we    = we;
        bus_re    = !we;
        cycles    = 0;
        rdata     = '0;
        for (int n = 0; n < 200 && !gotAck; n++) begin
            @(posedge clock); #1;
            cycles++;
            if (bus_ack) begin
                gotAck = 1;
                rdata  = bus_rdata;
            end
        end
        if (!gotAck) begin
            checks++;
            fails++;
            $display("[TB] FAIL ackTimeout: got no bus_ack, expected one within 200 cycles");
        end
        repeat (holdExtra) begin @(posedge clock); #1; end
        bus_we = 1'b0;
        bus_re = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic waitIrq(input int limit);
        for (int n = 0; n < limit && !irq; n++) begin @(posedge clock); #1; end
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic        empty, full, nack;
        logic [7:0]  dout;
        logic        chkRdata;
        logic [31:0] expRdata;
        int          expCycles;
        int          dEnq, dDeq, dRcnt, dClr;
        logic        chkDin;
        logic [7:0]  expDin;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] r;
        int          c;
        int e0, d0, rc0, cl0, x0;

        vecs[0]  = '{2'd3, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h01, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[1]  = '{2'd3, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[2]  = '{2'd3, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h11, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[3]  = '{2'd0, 1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00, 5, 1, 0, 0, 0, 1'b1, 8'hA5};
        vecs[4]  = '{2'd0, 1'b1, 32'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[5]  = '{2'd0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 32'h00, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[6]  = '{2'd0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 32'h3C, 5, 0, 1, 0, 0, 1'b0, 8'h00};
        vecs[7]  = '{2'd1, 1'b1, 32'h03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00, 5, 0, 0, 1, 0, 1'b1, 8'h03};
        vecs[8]  = '{2'd1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h03, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[9]  = '{2'd2, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h00, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[10] = '{2'd2, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00, 1, 0, 0, 0, 0, 1'b0, 8'h00};
        vecs[11] = '{2'd2, 1'b1, 32'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00, 5, 0, 0, 0, 1, 1'b0, 8'h00};
        vecs[12] = '{2'd3, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 32'h16, 1, 0, 0, 0, 0, 1'b0, 8'h00};

        reset = 1'b1; bus_addr = 2'd0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
        phy_dout = 8'h00; phy_nack = 1'b0; phy_empty = 1'b1; phy_full = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        checkOutput("resetAckIrq", {30'd0, bus_ack, irq}, 32'h0);
        checkOutput("resetPhyCmds", {26'd0, phy_read, phy_write, phy_rcount_set, phy_enq, phy_deq, phy_clear}, 32'h0);
        checkOutput("resetPhyDin", {24'd0, phy_din}, 32'h0);
        checkOutput("resetRdata", bus_rdata, 32'h0);

        phyDelay = 2;
        for (int i = 0; i < 13; i++) begin
            phy_empty = vecs[i].empty;
            phy_full  = vecs[i].full;
            phy_nack  = vecs[i].nack;
            phy_dout  = vecs[i].dout;
            e0 = enqCnt; d0 = deqCnt; rc0 = rcntCnt; cl0 = clrCnt; x0 = rdCnt + wrCnt;
            applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, 0, r, c);
            if (vecs[i].chkRdata) checkOutput($sformatf("vec%0d.rdata", i), r, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d.ackCycles", i), c, vecs[i].expCycles);
            checkOutput($sformatf("vec%0d.enq", i), enqCnt - e0, vecs[i].dEnq);
            checkOutput($sformatf("vec%0d.deq", i), deqCnt - d0, vecs[i].dDeq);
            checkOutput($sformatf("vec%0d.rcnt", i), rcntCnt - rc0, vecs[i].dRcnt);
            checkOutput($sformatf("vec%0d.clr", i), clrCnt - cl0, vecs[i].dClr);
            checkOutput($sformatf("vec%0d.xfer", i), rdCnt + wrCnt - x0, 0);
            if (vecs[i].chkDin) checkOutput($sformatf("vec%0d.din", i), {24'd0, lastDin}, {24'd0, vecs[i].expDin});
        end
        phy_empty = 1'b1; phy_full = 1'b0; phy_nack = 1'b0;

        // Background read transfer with bus traffic while busy.
        phyDelay = 10;
        x0 = rdCnt; e0 = enqCnt;
        applyStimulus(2'd2, 1'b1, 32'h2, 0, r, c);
        checkOutput("cmdReadAckCycles", c, 1);
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        checkOutput("busyStatus", r, 32'h19);
        checkOutput("readHeld", {31'd0, phy_read}, 32'h1);
        applyStimulus(2'd0, 1'b1, 32'h11, 0, r, c);
        checkOutput("busyDataWriteCycles", c, 1);
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        checkOutput("busyStatusAgain", r, 32'h19);
        waitIrq(100);
        checkOutput("irqOnDone", {31'd0, irq}, 32'h1);
        checkOutput("busyEnqSuppressed", enqCnt - e0, 0);
        checkOutput("readHandshakes", rdCnt - x0, 1);
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        checkOutput("doneStatus", r, 32'h31);
        applyStimulus(2'd3, 1'b1, 32'h30, 0, r, c);
        checkOutput("irqCleared", {31'd0, irq}, 32'h0);
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        checkOutput("statusAfterClear", r, 32'h11);

        // Write transfer.
        phyDelay = 2;
        x0 = wrCnt;
        applyStimulus(2'd2, 1'b1, 32'h1, 0, r, c);
        waitIrq(100);
        checkOutput("writeIrq", {31'd0, irq}, 32'h1);
        checkOutput("writeHandshakes", wrCnt - x0, 1);
        applyStimulus(2'd3, 1'b1, 32'h30, 0, r, c);

        // Done-clear landing in the completion cycle: completion wins.
        phyDelay = 4;
        applyStimulus(2'd2, 1'b1, 32'h2, 0, r, c);
        repeat (5) begin @(posedge clock); #1; end
        applyStimulus(2'd3, 1'b1, 32'h30, 0, r, c);
        checkOutput("completionWins", {31'd0, irq}, 32'h1);
        applyStimulus(2'd3, 1'b1, 32'h30, 0, r, c);
        checkOutput("clearAfterWin", {31'd0, irq}, 32'h0);

        // Held request must not re-issue; CMD 7 is a clear only.
        phyDelay = 2;
        cl0 = clrCnt; x0 = rdCnt + wrCnt;
        applyStimulus(2'd2, 1'b1, 32'h7, 5, r, c);
        repeat (4) begin @(posedge clock); #1; end
        checkOutput("singleClear", clrCnt - cl0, 1);
        checkOutput("clearNoXfer", rdCnt + wrCnt - x0, 0);

        // Reset in the middle of a transfer.
        phyDelay = 10;
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        applyStimulus(2'd2, 1'b1, 32'h2, 0, r, c);
        checkOutput("preResetRead", {31'd0, phy_read}, 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("midResetCmds", {26'd0, phy_read, phy_write, phy_rcount_set, phy_enq, phy_deq, phy_clear}, 32'h0);
        checkOutput("midResetAckIrq", {30'd0, bus_ack, irq}, 32'h0);
        checkOutput("midResetRdata", bus_rdata, 32'h0);
        checkOutput("midResetDin", {24'd0, phy_din}, 32'h0);
        reset = 1'b0;
        phyDelay = 2;
        applyStimulus(2'd3, 1'b0, 32'h0, 0, r, c);
        checkOutput("postResetStatus", r, 32'h01);

        checkOutput("oneHotCmds", oneHotErr, 0);
        checkOutput("dinStable", dinErr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/i2c_bus_bridge.md
Name: i2c_bus_bridge

Overview:
- Memory-mapped slave that sits between the processor data bus and the I2C master PHY.
- Converts single-cycle register accesses into the PHY's level-held, 4-way command handshake: enqueue/dequeue FIFO bytes, set the read count, clear the FIFO, and start read/write transactions.
- Exposes a status register and a level interrupt on transaction completion.
- Software polls or takes the interrupt; it never stalls for the length of an I2C transfer.

Parameters:
- BUS_W, 32: processor data width; only bits [7:0] of DATA/COUNT and the listed CMD/STATUS bits are meaningful, the rest read 0.
- IRQ_EN_RST, 0: reset value of the interrupt-enable bit.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- bus_addr  in  2  register select: 0 DATA, 1 COUNT, 2 CMD, 3 STATUS
- bus_wdata  in  BUS_W  write data
- bus_we  in  1  write request, held until bus_ack
- bus_re  in  1  read request, held until bus_ack
- bus_rdata  out  BUS_W  read data, valid in the bus_ack cycle
- bus_ack  out  1  single-cycle access completion pulse
- irq  out  1  done & irq_en
- phy_read, phy_write, phy_rcount_set, phy_enq, phy_deq, phy_clear  out  1 each  PHY command levels
- phy_din  out  8  byte to PHY (enqueue data or read count)
- phy_dout  in  8  byte dequeued by PHY
- phy_ack  in  1  PHY handshake acknowledge
- phy_nack  in  1  PHY latched no-acknowledge
- phy_empty, phy_full  in  1 each  PHY FIFO flags

Behaviour:
- Reset: all outputs 0; irq_en = IRQ_EN_RST; done = 0; busy = 0; FSM = IDLE. Reset mid-transaction abandons it; the PHY shares the reset.
- At most one phy_* command is high at any time. phy_din is stable while a command is high.
- PHY handshake (4-way):
  - assert the command until phy_ack = 1;
  - deassert all commands;
  - wait for phy_ack = 0;
  - the operation is then complete.
- FSM states: IDLE, S_REQ, S_REL, B_ACK, B_WAIT, T_REQ, T_REL.
- IDLE, on request (bus_we | bus_re):
  - DATA write: if phy_full, drop the byte and go to B_ACK. Otherwise phy_din = wdata[7:0], phy_enq, go to S_REQ.
  - DATA read: if phy_empty, rdata = 0 and go to B_ACK. Otherwise phy_deq, go to S_REQ.
  - COUNT write: phy_din = wdata[7:0], phy_rcount_set, go to S_REQ. COUNT read returns the last written count.
  - CMD write, priority bit2 CLEAR > bit1 READ > bit0 WRITE:
    - CLEAR: phy_clear, go to S_REQ.
    - READ or WRITE: phy_read/phy_write, busy = 1, done = 0, go to T_REQ; bus_ack pulses next cycle (non-blocking).
    - Value 0: go to B_ACK with no effect.
  - CMD read returns 0.
  - STATUS read: go to B_ACK with {done[5], irq_en[4], busy[3], phy_nack[2], phy_full[1], phy_empty[0]}.
  - STATUS write: irq_en = wdata[4]; wdata[5] = 1 clears done; go to B_ACK.
- S_REQ → S_REL on phy_ack = 1. On entering S_REL after a DATA read, capture phy_dout into rdata.
- S_REL → B_ACK on phy_ack = 0.
- B_ACK: bus_ack = 1 for one cycle, then B_WAIT.
- B_WAIT: wait until bus_we = bus_re = 0, then return to IDLE (or T_REQ/T_REL if busy). This prevents double-issue.
- T_REQ: hold phy_read/phy_write until phy_ack = 1, then T_REL with commands low.
- T_REL: on phy_ack = 0, busy = 0, done = 1, go to IDLE.
- Bus accesses while busy, served inside T_REQ/T_REL:
  - STATUS read/write behaves normally.
  - Every other access is acked in 1 cycle with no side effect; rdata = 0.
  - Re-arming waits for request release, as in B_WAIT.
- done is a sticky flag. A STATUS clear in the same cycle as completion is a simultaneous event: completion wins and done = 1.
- bus_rdata holds its value until the next read ack.

Test Plan:
- Reset, then STATUS read → bus_rdata = 0x01 (empty), irq = 0, all phy_* low.
- DATA write 0xA5 → phy_enq high with phy_din = 0xA5 until phy_ack, then low; bus_ack only after phy_ack falls.
- COUNT write 3, CMD write 0x2 → bus_ack within 2 cycles; phy_read held until phy_ack; STATUS shows busy = 1; after phy_ack falls, done = 1; with irq_en = 1, irq = 1.
- While busy, DATA write 0x11 → acked, phy_enq never asserted; STATUS read still correct. After done, write STATUS bit5 → irq = 0.
- DATA read with phy_empty = 1 → rdata = 0, no phy_deq. DATA read with a byte 0x3C → phy_deq handshake, rdata = 0x3C.
- CMD write 0x7 → only phy_clear asserted. Hold bus_we for 5 cycles after ack → exactly one phy_clear handshake. Reset asserted during T_REQ → all outputs 0 next cycle.
